// File: rtl/aura16_pkg.sv
// Shared AURA16 widths, reset PC, NOP encoding, fetch FSM states and the IF/ID record.
// Pure declarations: no logic, no latency, no flow control.
package aura16_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
  } if_id_t;
endpackage

// File: rtl/aura16_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and an async-read memory (slave).
// Combinational read: data answers the address in the same cycle; no backpressure.
interface aura16_fetch_stage_if;
  import aura16_pkg::*;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/aura16_if_id_reg.sv
// IF/ID pipeline register: squash clears to a zeroed bubble, load captures, otherwise hold.
// 1-cycle latency; hold (neither control) is how upstream stalls back-pressure the stage.
module aura16_if_id_reg
  import aura16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              squash,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  output if_id_t            if_id
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id <= '0;
    end else if (squash) begin
      if_id <= '0;
    end else if (load) begin
      if_id <= '{valid: 1'b1, instr: instr_in, pc: pc_in, pc_plus1: pc_in + ADDR_W'(1)};
    end
  end
endmodule

// File: rtl/aura16_fetch_stage.sv
// AURA16 fetch: PC drives async imem, word lands in IF/ID one cycle later; redirect > stall > advance.
// Optional AURA16_FETCH_BOUNDS_CHECK_EN traps fetches at PC >= IMEM_DEPTH into a sticky FAULT state.
module aura16_fetch_stage
  import aura16_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                IMEM_DEPTH = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aura16_fetch_stage_if.master imem,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic                 if_id_valid,
  output logic [DATA_W-1:0]    if_id_instr,
  output logic [ADDR_W-1:0]    if_id_pc,
  output logic [ADDR_W-1:0]    if_id_pc_plus1,
  output logic [15:0]          fetch_count,
  output logic                 fetch_fault
);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       count_q, count_d;
  logic              load, squash;
  logic              fault_trip;
  if_id_t            if_id;

`ifdef AURA16_FETCH_BOUNDS_CHECK_EN
  assign fault_trip  = (32'(pc_q) >= IMEM_DEPTH);
  assign fetch_fault = (state_q == FAULT);
`else
  logic unused_depth_cmp;
  assign unused_depth_cmp = (32'(pc_q) >= IMEM_DEPTH);
  assign fault_trip  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    load    = 1'b0;
    squash  = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d   = redirect_pc;
          squash = 1'b1;
        end else if (!stall) begin
          if (fault_trip) begin
            state_d = FAULT;
            squash  = 1'b1;
          end else begin
            load = 1'b1;
            pc_d = pc_q + ADDR_W'(1);
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          end
        end
      end
      // Frozen until reset; keep IF/ID cleared whatever the inputs do.
      FAULT:   squash  = 1'b1;
      default: state_d = RUN;
    endcase
  end

  aura16_if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .squash   (squash),
    .instr_in (imem.imem_data),
    .pc_in    (pc_q),
    .if_id    (if_id)
  );

  assign imem.imem_addr  = pc_q;
  assign if_id_valid     = if_id.valid;
  assign if_id_instr     = if_id.instr;
  assign if_id_pc        = if_id.pc;
  assign if_id_pc_plus1  = if_id.pc_plus1;
  assign fetch_count     = count_q;
endmodule

// File: tb/tb_aura16_fetch_stage.sv
// Scoreboarded bench for aura16_fetch_stage: expected IF/ID records queued at drive time, popped after the edge.
module tb_aura16_fetch_stage;
  import aura16_pkg::*;

`ifdef AURA16_FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus1;
  logic [15:0] fetch_count;
  logic        fetch_fault;
  logic [15:0] mem [0:65535];

  aura16_fetch_stage_if imem_bus ();
  assign imem_bus.imem_data = mem[imem_bus.imem_addr];

  aura16_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem_bus.master),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .fetch_count    (fetch_count),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  exp_t last_exp;
  logic [15:0] exp_pc;
  logic [15:0] exp_cnt;
  logic        exp_fault;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h @%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check_val("if_id_valid", 32'(if_id_valid), 32'(e.valid));
    check_val("if_id_instr", 32'(if_id_instr), 32'(e.instr));
    check_val("if_id_pc", 32'(if_id_pc), 32'(e.pc));
    check_val("if_id_pc_plus1", 32'(if_id_pc_plus1), 32'(e.pc_plus1));
    check_val("imem_addr", 32'(imem_bus.imem_addr), 32'(exp_pc));
    check_val("fetch_count", 32'(fetch_count), 32'(exp_cnt));
    check_val("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
  endtask

  // Drive one cycle of inputs, predict the IF/ID record, then compare after the edge.
  task automatic step(input logic st, input logic rv, input logic [15:0] rp);
    exp_t e;
    exp_t got;
    stall = st;
    redirect_valid = rv;
    redirect_pc = rp;
    if (exp_fault) begin
      e = '0;
    end else if (rv) begin
      e = '0;
      exp_pc = rp;
    end else if (st) begin
      e = last_exp;
    end else if (BOUNDS && exp_pc >= 16'd512) begin
      e = '0;
      exp_fault = 1'b1;
    end else begin
      e = '{valid: 1'b1, instr: mem[exp_pc], pc: exp_pc, pc_plus1: exp_pc + 16'd1};
      exp_pc = exp_pc + 16'd1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    sb_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_outputs(got);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_pc = 16'h0000;
    exp_cnt = 16'h0000;
    exp_fault = 1'b0;
    last_exp = '0;
    sb_q.delete();
    check_outputs('0);
    @(posedge clk);
    #1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    rst_n = 1'b1;
  endtask

  logic [15:0] prog [0:3];

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7 + 16'h1234);
    prog[0] = 16'h3045; prog[1] = 16'h3085; prog[2] = 16'h6281; prog[3] = 16'h30C9;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];
    #2;
    do_reset();

    // Straight-line fetch of words 0..3.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'h0);
      check_val("prog_instr", 32'(if_id_instr), 32'(prog[i]));
      check_val("prog_pc", 32'(if_id_pc), i);
    end
    check_val("count_after_4", 32'(fetch_count), 32'd4);

    // Stall with pc 1 in IF/ID for three cycles.
    do_reset();
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0);
      check_val("stall_pc_hold", 32'(if_id_pc), 32'd1);
      check_val("stall_addr_hold", 32'(imem_bus.imem_addr), 32'd2);
    end
    step(1'b0, 1'b0, 16'h0);
    check_val("resume_instr", 32'(if_id_instr), 32'h6281);
    step(1'b0, 1'b0, 16'h0);

    // Redirect wins over a simultaneous stall.
    step(1'b1, 1'b1, 16'd8);
    check_val("redir_bubble", 32'(if_id_valid), 32'd0);
    check_val("redir_addr", 32'(imem_bus.imem_addr), 32'd8);
    step(1'b0, 1'b0, 16'h0);
    check_val("redir_target_pc", 32'(if_id_pc), 32'd8);
    check_val("redir_target_plus1", 32'(if_id_pc_plus1), 32'd9);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0);
    check_val("wrap_pc", 32'(if_id_pc), 32'h0000FFFF);
    check_val("wrap_plus1", 32'(if_id_pc_plus1), 32'h0);
    step(1'b0, 1'b0, 16'h0);
    check_val("wrap_next_pc", 32'(if_id_pc), 32'h0);

    // Fetch just past physical memory depth.
    step(1'b0, 1'b1, 16'd512);
    step(1'b0, 1'b0, 16'h0);
    check_val("oob_fault", 32'(fetch_fault), 32'(BOUNDS));
    check_val("oob_valid", 32'(if_id_valid), 32'(!BOUNDS));
    step(1'b0, 1'b1, 16'd3);
    step(1'b0, 1'b0, 16'h0);

    // Async reset in the middle of a stalled redirect.
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h1234;
    #2;
    do_reset();

    // Count to saturation, steering the PC away from the depth limit.
    while (exp_cnt != 16'hFFFF) begin
      if (exp_pc == 16'd500) step(1'b0, 1'b1, 16'h0);
      else step(1'b0, 1'b0, 16'h0);
    end
    check_val("count_full", 32'(fetch_count), 32'h0000FFFF);
    step(1'b0, 1'b0, 16'h0);
    check_val("count_saturated", 32'(fetch_count), 32'h0000FFFF);
    check_val("sat_valid", 32'(if_id_valid), 32'd1);

    // Reset pulse mid-run.
    step(1'b0, 1'b0, 16'h0);
    #2;
    do_reset();
    step(1'b0, 1'b0, 16'h0);
    check_val("post_reset_first", 32'(if_id_instr), 32'h3045);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
